seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a bank of common-anode/common-cathode seven-segment digits. Decodes one 4-bit hex nibble per digit, applies leading-zero and per-digit blanking, and scans the digits with dead-time and 16-level brightness control. Digit data is double-buffered and applied only at frame boundaries, so a frame never mixes old and new values. Sits between the time-keeping counters and the board display pins.

---
 rtl/seven_segment_pkg.sv | 24 ++
 rtl/seven_segment_scanner_if.sv | 22 ++
 rtl/seven_segment_glyph.sv | 11 +
 rtl/seven_segment_scanner.sv | 133 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared constants and glyph table for the seven-segment scanner
package seven_segment_pkg;

  localparam int PHASES = 16;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, segment A at bit 0 ... G at bit 6
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - digit data load interface between counters and scanner
interface seven_segment_scanner_if #(
  parameter int DIGITS = 6
);
  logic                  load;
  logic [4*DIGITS-1:0]   digitValues;
  logic [DIGITS-1:0]     decimalPoints;
  logic [DIGITS-1:0]     blankMask;
  logic                  leadingZeroBlank;
  logic [3:0]            brightness;
  logic                  loadPending;

  modport master (
    output load, digitValues, decimalPoints, blankMask, leadingZeroBlank, brightness,
    input  loadPending
  );

  modport slave (
    input  load, digitValues, decimalPoints, blankMask, leadingZeroBlank, brightness,
    output loadPending
  );
endinterface

// File: rtl/seven_segment_glyph.sv
// rtl/seven_segment_glyph.sv - combinational hex nibble to active-high segment glyph
module seven_segment_glyph
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = glyph_of(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed seven-segment driver with double-buffered digit data
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int PHASE_CYCLES   = 256,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clock,
  input  logic                 resetN,
  seven_segment_scanner_if.slave host,
  output logic                 frameStart,
  output logic [6:0]           segments,
  output logic                 decimalPoint,
  output logic [DIGITS-1:0]    anodes
);

  localparam int CYC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PHASE_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [3:0]       PHASE_LAST = 4'(PHASES - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] values;
    logic [DIGITS-1:0]   dps;
    logic [DIGITS-1:0]   blank;
    logic                lzb;
    logic [3:0]          bright;
  } frame_t;

  localparam frame_t FRAME_RESET = '{values: '0, dps: '0, blank: '0, lzb: 1'b0, bright: 4'hF};

  logic [CYC_W-1:0] cycle_cnt;
  logic [3:0]       phase;
  logic [DIG_W-1:0] digit_idx;
  logic             boundary;
  frame_t           incoming, staging, shadow;
  logic             pending;
  logic [3:0]       nib [DIGITS];
  logic [DIGITS-1:0] lz_mask;
  logic             run_zero;
  logic [6:0]       glyph;
  logic             window, seg_on, dp_on;
  logic [DIGITS-1:0] an_sel;

  assign incoming = '{values: host.digitValues, dps: host.decimalPoints, blank: host.blankMask,
                      lzb: host.leadingZeroBlank, bright: host.brightness};
  assign boundary = (digit_idx == DIG_LAST) && (phase == PHASE_LAST) && (cycle_cnt == CYC_LAST);
  assign host.loadPending = pending;

  // Cascaded scan counters: cycle -> brightness phase -> digit slot
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cycle_cnt <= '0;
      phase     <= '0;
      digit_idx <= '0;
    end else if (cycle_cnt != CYC_LAST) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end else begin
      cycle_cnt <= '0;
      if (phase != PHASE_LAST) begin
        phase <= phase + 1'b1;
      end else begin
        phase     <= '0;
        digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Double buffer: staging captures loads, shadow swaps only at the frame boundary
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      staging <= FRAME_RESET;
      shadow  <= FRAME_RESET;
      pending <= 1'b0;
    end else if (host.load && boundary) begin
      // staging tracks shadow so the next boundary does not revert this write
      staging <= incoming;
      shadow  <= incoming;
      pending <= 1'b0;
    end else if (host.load) begin
      staging <= incoming;
      pending <= 1'b1;
    end else if (boundary) begin
      shadow  <= staging;
      pending <= 1'b0;
    end
  end

  // Leading-zero mask: a digit is suppressed while it and every digit above it are zero
  always_comb begin
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = shadow.values[4*i +: 4];
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero   = run_zero & (nib[i] == 4'h0);
      lz_mask[i] = run_zero;
    end
  end

  seven_segment_glyph u_glyph (
    .nibble (nib[digit_idx]),
    .glyph  (glyph)
  );

  // Lit window excludes dead-time phase 0 and phases above the brightness level
  always_comb begin
    window = (phase != 4'd0) && (phase <= shadow.bright);
    seg_on = window && !shadow.blank[digit_idx] && !(shadow.lzb && lz_mask[digit_idx]);
    dp_on  = window && !shadow.blank[digit_idx] && shadow.dps[digit_idx];
    an_sel = window ? (DIGITS'(1) << digit_idx) : '0;
  end

  // Output registers, the only place polarity is applied
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frameStart   <= 1'b0;
      segments     <= {7{SEG_ACTIVE_LOW}};
      decimalPoint <= SEG_ACTIVE_LOW;
      anodes       <= {DIGITS{AN_ACTIVE_LOW}};
    end else begin
      frameStart   <= (digit_idx == '0) && (phase == 4'd0) && (cycle_cnt == '0);
      segments     <= (seg_on ? glyph : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
      decimalPoint <= dp_on ^ SEG_ACTIVE_LOW;
      anodes       <= an_sel ^ {DIGITS{AN_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

  logic       clock = 1'b0;
  logic       resetN;
  logic       frameStart;
  logic [6:0] segments;
  logic       decimalPoint;
  logic [5:0] anodes;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  int active;

  seven_segment_scanner_if #(.DIGITS(6)) host();

  seven_segment_scanner #(
    .DIGITS(6), .PHASE_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .resetN(resetN), .host(host),
    .frameStart(frameStart), .segments(segments),
    .decimalPoint(decimalPoint), .anodes(anodes)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    edges++;
  endtask

  task automatic wait_edges(input int n);
    if (edges > n) begin
      miscompares++;
      $error("FAIL schedule edges=%0d target=%0d", edges, n);
    end
    while (edges < n) step();
  endtask

  // Outputs after edge t+1 reflect counter state t
  task automatic at_t(input int t);
    wait_edges(t + 1);
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bm,
                         input logic lzb, input logic [3:0] br);
    host.digitValues      = v;
    host.decimalPoints    = dp;
    host.blankMask        = bm;
    host.leadingZeroBlank = lzb;
    host.brightness       = br;
    host.load             = 1'b1;
    step();
    host.load             = 1'b0;
  endtask

  initial begin
    host.load = 1'b0;
    host.digitValues = '0;
    host.decimalPoints = '0;
    host.blankMask = '0;
    host.leadingZeroBlank = 1'b0;
    host.brightness = 4'hF;
    resetN = 1'b1;
    #2 resetN = 1'b0;
    #1;
    chk("rst_anodes", anodes, 6'h3F);
    chk("rst_segments", segments, 7'h00);
    chk("rst_dp", decimalPoint, 1'b0);
    chk("rst_frame_start", frameStart, 1'b0);
    chk("rst_pending", host.loadPending, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 resetN = 1'b1;
    edges = 0;

    step();
    chk("first_frame_start", frameStart, 1'b1);
    chk("first_dead_time", anodes, 6'h3F);
    at_t(2);
    chk("reset_shadow_seg", segments, 7'h3F);
    chk("reset_shadow_an", anodes, 6'h3E);
    chk("frame_start_low", frameStart, 1'b0);

    do_load(24'h123456, 6'h00, 6'h00, 1'b0, 4'hF);
    chk("pending_set", host.loadPending, 1'b1);
    at_t(34);
    chk("unchanged_d1_seg", segments, 7'h3F);
    chk("unchanged_d1_an", anodes, 6'h3D);
    at_t(190);
    chk("pending_before_bnd", host.loadPending, 1'b1);
    at_t(192);
    chk("f1_frame_start", frameStart, 1'b1);
    chk("f1_pending_clr", host.loadPending, 1'b0);
    chk("f1_dead_time", anodes, 6'h3F);
    at_t(194);
    chk("f1_d0_seg", segments, 7'h7D);
    chk("f1_d0_an", anodes, 6'h3E);
    at_t(223);
    chk("f1_d0_phase15_an", anodes, 6'h3E);
    at_t(226);
    chk("f1_d1_seg", segments, 7'h6D);
    chk("f1_d1_an", anodes, 6'h3D);

    wait_edges(250);
    do_load(24'h000A0F, 6'b000010, 6'h00, 1'b1, 4'hF);
    at_t(386);
    chk("lz_d0_seg", segments, 7'h71);
    at_t(418);
    chk("lz_d1_seg", segments, 7'h3F);
    chk("lz_d1_dp", decimalPoint, 1'b1);
    at_t(450);
    chk("lz_d2_seg", segments, 7'h77);
    at_t(482);
    chk("lz_d3_seg", segments, 7'h00);
    chk("lz_d3_an", anodes, 6'h37);
    at_t(546);
    chk("lz_d5_seg", segments, 7'h00);

    wait_edges(560);
    do_load(24'h000000, 6'b000010, 6'h00, 1'b1, 4'hF);
    at_t(578);
    chk("zero_d0_seg", segments, 7'h3F);
    at_t(610);
    chk("zero_d1_seg", segments, 7'h00);
    chk("zero_d1_dp", decimalPoint, 1'b1);
    at_t(642);
    chk("zero_d2_seg", segments, 7'h00);

    wait_edges(700);
    do_load(24'h123456, 6'h00, 6'h00, 1'b0, 4'd4);
    active = 0;
    for (int t = 768; t < 800; t++) begin
      at_t(t);
      if (anodes !== 6'h3F) active++;
    end
    chk("bright4_lit_cycles", active, 8);
    at_t(809);
    chk("bright4_ph4_seg", segments, 7'h6D);
    chk("bright4_ph4_an", anodes, 6'h3D);
    at_t(810);
    chk("bright4_ph5_an", anodes, 6'h3F);
    chk("bright4_ph5_seg", segments, 7'h00);

    wait_edges(820);
    do_load(24'h123456, 6'h00, 6'h00, 1'b0, 4'd0);
    active = 0;
    for (int t = 960; t < 1152; t++) begin
      at_t(t);
      if (anodes !== 6'h3F) active++;
    end
    chk("bright0_active", active, 0);

    wait_edges(1160);
    do_load(24'h123456, 6'b000001, 6'b000001, 1'b0, 4'hF);
    at_t(1346);
    chk("blank_d0_seg", segments, 7'h00);
    chk("blank_d0_dp", decimalPoint, 1'b0);
    at_t(1378);
    chk("blank_d1_seg", segments, 7'h6D);

    wait_edges(1400);
    do_load(24'h111111, 6'h00, 6'h00, 1'b0, 4'hF);
    wait_edges(1410);
    do_load(24'h222222, 6'h00, 6'h00, 1'b0, 4'hF);
    chk("double_pending", host.loadPending, 1'b1);
    at_t(1442);
    chk("double_old_d3_seg", segments, 7'h4F);
    chk("double_old_d3_an", anodes, 6'h37);
    at_t(1538);
    chk("double_new_d0_seg", segments, 7'h5B);
    chk("double_pending_clr", host.loadPending, 1'b0);
    at_t(1570);
    chk("double_new_d1_seg", segments, 7'h5B);

    wait_edges(1727);
    do_load(24'h333333, 6'h00, 6'h00, 1'b0, 4'hF);
    chk("bnd_no_pending", host.loadPending, 1'b0);
    step();
    chk("bnd_no_pending2", host.loadPending, 1'b0);
    at_t(1730);
    chk("bnd_d0_seg", segments, 7'h4F);
    chk("bnd_d0_an", anodes, 6'h3E);
    at_t(1762);
    chk("bnd_d1_seg", segments, 7'h4F);

    wait_edges(1770);
    do_load(24'h444444, 6'h00, 6'h00, 1'b0, 4'hF);
    chk("pre_rst_pending", host.loadPending, 1'b1);
    at_t(1779);
    chk("pre_rst_an", anodes, 6'h3D);
    #2 resetN = 1'b0;
    #1;
    chk("async_rst_an", anodes, 6'h3F);
    chk("async_rst_seg", segments, 7'h00);
    chk("async_rst_pending", host.loadPending, 1'b0);
    @(posedge clock);
    #1 resetN = 1'b1;
    edges = 0;
    step();
    chk("post_rst_frame_start", frameStart, 1'b1);
    at_t(2);
    chk("post_rst_d0_seg", segments, 7'h3F);
    at_t(194);
    chk("post_rst_discard_seg", segments, 7'h3F);
    chk("post_rst_pending", host.loadPending, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
